// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
`timescale 1ns/1ps
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_e;

    // Down-counter width able to hold the larger of the two reload values.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned stagger);
        int unsigned m;
        m = (hold > stagger) ? hold : stagger;
        return 32'($clog2(m + 1));
    endfunction

    function automatic int unsigned idx_width(input int unsigned channels);
        return (channels > 1) ? 32'($clog2(channels)) : 32'd1;
    endfunction

endpackage

// File: rtl/reset_seq_sync_chain.sv
// Multi-flop synchronizer with asynchronous active-low clear to zero.
`timescale 1ns/1ps
module sync_chain #(
    parameter int unsigned WIDTH_P = 1,
    parameter int unsigned DEPTH_P = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] d_i,
    output logic [WIDTH_P-1:0] q_o
);

    logic [DEPTH_P-1:0][WIDTH_P-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH_P); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH_P-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: async assert, synchronous in-order release after a stretch.
// Define RESET_SEQ_LOCK_EN to gate sequencing on a synchronized PLL lock.
`timescale 1ns/1ps
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned sync_depth_p     = 2,
    parameter int unsigned hold_cycles_p    = 16,
    parameter int unsigned channels_p       = 4,
    parameter int unsigned stagger_cycles_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_async_unsafe_i,
    input  logic                  lock_i,
    input  logic                  sw_reset_i,
    output logic [channels_p-1:0] reset_o,
    output logic                  ready_o
);

    localparam int unsigned CNT_W = cnt_width(hold_cycles_p, stagger_cycles_p);
    localparam int unsigned IDX_W = idx_width(channels_p);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(hold_cycles_p - 1);
    localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(stagger_cycles_p - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(channels_p - 1);

    logic rst_sync;
    logic lock_sync;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [channels_p-1:0] reset_q, reset_d;
    logic                  ready_q, ready_d;

    sync_chain #(.WIDTH_P(1), .DEPTH_P(sync_depth_p)) u_rst_sync (
        .clk_i  (clk_i),
        .rst_ni (reset_n_async_unsafe_i),
        .d_i    (1'b1),
        .q_o    (rst_sync)
    );

`ifdef RESET_SEQ_LOCK_EN
    sync_chain #(.WIDTH_P(1), .DEPTH_P(sync_depth_p)) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (reset_n_async_unsafe_i),
        .d_i    (lock_i),
        .q_o    (lock_sync)
    );
`else
    logic unused_lock;
    assign unused_lock = lock_i;
    assign lock_sync   = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            reset_q <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            reset_q <= reset_d;
            ready_q <= ready_d;
        end
    end

    // Lock loss outranks a soft reset; soft reset is only honoured once sequencing started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ASSERT: begin
                if (rst_sync) state_d = lock_sync ? ST_STRETCH : ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync) state_d = ST_STRETCH;
            end
            ST_STRETCH, ST_RELEASE, ST_RUN: begin
                if (!lock_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (sw_reset_i) begin
                    state_d = ST_STRETCH;
                end else if (state_q == ST_STRETCH && cnt_q == '0) begin
                    state_d = (channels_p == 1) ? ST_RUN : ST_RELEASE;
                end else if (state_q == ST_RELEASE && cnt_q == '0 && idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    // Counter, channel index and registered outputs.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        reset_d = reset_q;
        ready_d = ready_q;
        case (state_q)
            ST_ASSERT, ST_WAIT_LOCK: begin
                if (state_d == ST_STRETCH) cnt_d = HOLD_LOAD;
            end
            ST_STRETCH, ST_RELEASE, ST_RUN: begin
                if (!lock_sync || sw_reset_i) begin
                    reset_d = '1;
                    ready_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = HOLD_LOAD;
                end else if (state_q == ST_STRETCH) begin
                    if (cnt_q == '0) begin
                        reset_d[0] = 1'b0;
                        idx_d      = IDX_W'(1);
                        cnt_d      = STAG_LOAD;
                        ready_d    = (channels_p == 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == '0) begin
                        for (int i = 0; i < int'(channels_p); i++) begin
                            if (IDX_W'(i) == idx_q) reset_d[i] = 1'b0;
                        end
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = STAG_LOAD;
                        ready_d = (idx_q == LAST_IDX);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                reset_d = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign reset_o = reset_q;
    assign ready_o = ready_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised successor to the two-flop reset synchronizer in the icebreaker top level. It takes the raw board reset and an optional PLL lock indication. It produces `channels_p` active-high reset outputs that assert asynchronously and release synchronously, one at a time and in order, after a programmable stretch. It sits directly behind the PLL and drives every downstream reset domain, for example UART, core and peripherals.

## Interface
- `sync_depth_p`, 2: synchronizer flop count for reset release and lock; legal range ≥2.
- `hold_cycles_p`, 16: stretch cycles after synchronized release and lock; legal range ≥1.
- `channels_p`, 4: number of reset outputs; legal range 1..16.
- `stagger_cycles_p`, 8: cycles between successive channel releases; legal range ≥1.
- `clk_i` in 1: single clock, the PLL output.
- `reset_n_async_unsafe_i` in 1: asynchronous, active-low reset. It is also the raw reset being conditioned.
- `lock_i` in 1: asynchronous PLL lock, active high.
- `sw_reset_i` in 1: synchronous soft-reset request, one-cycle pulse or level.
- `reset_o` out `channels_p`: per-domain reset, active high; bit 0 is released first.
- `ready_o` out 1: high once every channel is released.

## Operation
- While `reset_n_async_unsafe_i` is low, all flops are cleared immediately:
  - `reset_o` = all ones, `ready_o` = 0, state = ASSERT.
  - Synchronizer flops = 0.
- Release path: `reset_n_async_unsafe_i` passes through a `sync_depth_p` chain to give `rst_sync`. `lock_i` passes through an identical chain to give `lock_sync`.
- FSM states: ASSERT, WAIT_LOCK, STRETCH, RELEASE, RUN.
  - ASSERT: when `rst_sync` = 1, go to STRETCH if `lock_sync` = 1, else to WAIT_LOCK.
  - WAIT_LOCK: when `lock_sync` = 1, go to STRETCH.
  - STRETCH: stay exactly `hold_cycles_p` cycles. On exit, go to RELEASE and deassert `reset_o[0]`.
  - RELEASE: every `stagger_cycles_p` cycles, deassert the next `reset_o` bit in index order. On the edge that deasserts bit `channels_p-1`, go to RUN and set `ready_o` = 1.
  - RUN: hold until an abort event.
- Abort events, evaluated in STRETCH, RELEASE and RUN:
  - `lock_sync` = 0: on the next edge, all `reset_o` = 1, `ready_o` = 0, state = WAIT_LOCK.
  - `sw_reset_i` = 1: on the next edge, all `reset_o` = 1, `ready_o` = 0, state = STRETCH, counter restarts.
  - Both at once: lock loss wins.
  - `sw_reset_i` is ignored in ASSERT and WAIT_LOCK.
- `channels_p` = 1: STRETCH exit deasserts `reset_o[0]`, sets `ready_o`, and enters RUN directly.
- Already-released bits never re-deassert out of order. `reset_o` is always a thermometer: released bits are the contiguous low bits.

## Timing
- Assertion from `reset_n_async_unsafe_i` low to `reset_o` high is combinational through the async clear. There is no clock dependence.
- Deassertion example: defaults, `lock_i` tied high, `reset_n` rising between edges E0 and E1.
  - `rst_sync` goes high after E2.
  - ASSERT→STRETCH at E3.
  - `reset_o[0]` falls at E19, `[1]` at E27, `[2]` at E35.
  - `[3]` falls and `ready_o` rises at E43.
- Lock loss: `reset_o` reasserts `sync_depth_p` + 1 edges after `lock_i` falls.
- `sw_reset_i` is sampled at edge N. `reset_o` is all ones after edge N. `reset_o[0]` falls at edge N + `hold_cycles_p`.
- Arithmetic and widths:
  - Cycle counter is `$clog2(max(hold_cycles_p, stagger_cycles_p)+1)` bits, counts down, and never wraps.
  - Channel index is `$clog2(channels_p)` bits, minimum 1.

## Configuration
- `RESET_SEQ_LOCK_EN` defined: `lock_i` is synchronized and gates sequencing as described.
- `RESET_SEQ_LOCK_EN` undefined:
  - `lock_sync` is constant 1 and the lock synchronizer is not instantiated.
  - WAIT_LOCK is unreachable and lock-loss aborts never occur.
  - The `lock_i` port remains present and unused.

## Structure
- Package `reset_seq_pkg` holds:
  - `state_e` enum for the five states.
  - Width helper function for counter sizing.
- Sub-module `sync_chain`:
  - Parameters: width and depth.
  - Behaviour: async active-low clear to 0.
  - Instantiated for reset release and, under the macro, for lock.

## Test plan
- Power-on, defaults, lock high, reset released mid-cycle:
  - `reset_o` = 4'b1111 until E19.
  - Then 4'b1110, 4'b1100 (E27), 4'b1000 (E35), 4'b0000 with `ready_o` = 1 (E43).
- Lock held low for 100 cycles after reset release:
  - State stays WAIT_LOCK and `reset_o` = 4'b1111.
  - After lock rises, `reset_o[0]` falls `sync_depth_p` + 1 + 16 edges later.
- Lock drops while `reset_o` = 4'b1100:
  - 3 edges later `reset_o` = 4'b1111 and `ready_o` = 0.
  - On relock, the full sequence repeats.
- `sw_reset_i` pulse in RUN at edge N: `reset_o` = 4'b1111 after N, `reset_o[0]` falls at N+16, `ready_o` returns at N+40.
- `reset_n_async_unsafe_i` pulsed low for 3 ns between edges during RELEASE: `reset_o` goes to 4'b1111 immediately and the sequence restarts from ASSERT.
- `channels_p` = 1, `hold_cycles_p` = 1, macro undefined: `reset_o` and `ready_o` toggle on the same edge, 2 edges after `rst_sync` rises.
